// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Package     : cpu_ctrl_pkg
// Description : Opcode/funct encodings, control codes, the decode bundle and
//               the decode-stage state type shared across the control path.
// Revision    : 1.0 - initial release
//============================================================================
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;

    localparam logic [4:0] RT_BLTZ    = 5'd0;
    localparam logic [4:0] RT_BGEZ    = 5'd1;

    localparam logic [4:0] ALU_NOP    = 5'd0;
    localparam logic [4:0] ALU_ADD    = 5'd1;
    localparam logic [4:0] ALU_SUB    = 5'd2;
    localparam logic [4:0] ALU_AND    = 5'd3;
    localparam logic [4:0] ALU_OR     = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_NOR    = 5'd6;
    localparam logic [4:0] ALU_MUL    = 5'd7;

    localparam logic [2:0] PAT_NONE   = 3'd0;
    localparam logic [2:0] PAT_GTZ    = 3'd1;
    localparam logic [2:0] PAT_NE     = 3'd2;
    localparam logic [2:0] PAT_LEZ    = 3'd3;
    localparam logic [2:0] PAT_LTZ    = 3'd4;
    localparam logic [2:0] PAT_GEZ    = 3'd5;

    localparam logic [2:0] JMP_NONE   = 3'd0;
    localparam logic [2:0] JMP_J      = 3'd1;
    localparam logic [2:0] JMP_JR     = 3'd2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_EXC_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic       ext_op;
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src;
        logic       sign;
        logic       is_r;
        logic [4:0] alu_op;
        logic [2:0] pattern;
        logic [2:0] jump;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/decode_ctrl_stage_if.sv
`default_nettype none
//============================================================================
// Interface   : decode_ctrl_stage_if
// Description : Instruction-in / control-bundle-out handshake plus the
//               multiply-busy and exception side signals of the decode stage.
// Revision    : 1.0 - initial release
//============================================================================
interface decode_ctrl_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            ext_op;
    logic            reg_dst;
    logic            branch;
    logic            mem_read;
    logic            mem_to_reg;
    logic            mem_write;
    logic            reg_write;
    logic            alu_src;
    logic            sign;
    logic            is_r;
    logic [4:0]      alu_op;
    logic [2:0]      pattern;
    logic [2:0]      jump;
    logic            mul_busy;
    logic            exc_valid;
    logic [XLEN-1:0] exc_addr;
    logic            exc_ack;

    modport slave (
        input  in_valid, instr, pc_plus4, flush, out_ready, exc_ack,
        output in_ready, out_valid, ext_op, reg_dst, branch, mem_read,
               mem_to_reg, mem_write, reg_write, alu_src, sign, is_r,
               alu_op, pattern, jump, mul_busy, exc_valid, exc_addr
    );

    modport master (
        output in_valid, instr, pc_plus4, flush, out_ready, exc_ack,
        input  in_ready, out_valid, ext_op, reg_dst, branch, mem_read,
               mem_to_reg, mem_write, reg_write, alu_src, sign, is_r,
               alu_op, pattern, jump, mul_busy, exc_valid, exc_addr
    );
endinterface
`default_nettype wire

// File: rtl/decode_ctrl_stage_instr_decoder.sv
`default_nettype none
//============================================================================
// Module      : instr_decoder
// Description : Combinational opcode/funct/rt to control-bundle decode with
//               an undefined-encoding flag.
// Revision    : 1.0 - initial release
//============================================================================
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [4:0] i_rt,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl,
    output logic       o_undef,
    output logic       o_is_mult
);

    always_comb begin
        o_ctrl    = '0;
        o_undef   = 1'b0;
        o_is_mult = 1'b0;
        case (i_op)
            OP_SPECIAL: begin
                case (i_funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        o_ctrl.reg_dst   = 1'b1;
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.is_r      = 1'b1;
                        o_ctrl.sign      = (i_funct == FN_ADD) || (i_funct == FN_SUB);
                        case (i_funct)
                            FN_ADD, FN_ADDU: o_ctrl.alu_op = ALU_ADD;
                            FN_SUB, FN_SUBU: o_ctrl.alu_op = ALU_SUB;
                            FN_AND:          o_ctrl.alu_op = ALU_AND;
                            FN_OR:           o_ctrl.alu_op = ALU_OR;
                            FN_XOR:          o_ctrl.alu_op = ALU_XOR;
                            default:         o_ctrl.alu_op = ALU_NOR;
                        endcase
                    end
                    FN_MULT: begin
                        o_ctrl.alu_op    = ALU_MUL;
                        o_ctrl.reg_dst   = 1'b1;
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.is_r      = 1'b1;
                        o_ctrl.sign      = 1'b1;
                        o_is_mult        = 1'b1;
                    end
                    FN_JR: begin
                        o_ctrl.branch = 1'b1;
                        o_ctrl.jump   = JMP_JR;
                        o_ctrl.alu_op = ALU_ADD;
                    end
                    default: o_undef = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.ext_op    = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.sign      = (i_op == OP_ADDI);
            end
            OP_ANDI: begin
                o_ctrl.alu_op    = ALU_AND;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            OP_BGTZ, OP_BNE, OP_BLEZ: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.alu_op = ALU_SUB;
                o_ctrl.ext_op = 1'b1;
                o_ctrl.is_r   = (i_op == OP_BNE);
                case (i_op)
                    OP_BGTZ: o_ctrl.pattern = PAT_GTZ;
                    OP_BNE:  o_ctrl.pattern = PAT_NE;
                    default: o_ctrl.pattern = PAT_LEZ;
                endcase
            end
            OP_REGIMM: begin
                if (i_rt == RT_BLTZ || i_rt == RT_BGEZ) begin
                    o_ctrl.branch  = 1'b1;
                    o_ctrl.alu_op  = ALU_SUB;
                    o_ctrl.ext_op  = 1'b1;
                    o_ctrl.pattern = (i_rt == RT_BLTZ) ? PAT_LTZ : PAT_GEZ;
                end else begin
                    o_undef = 1'b1;
                end
            end
            OP_J: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.jump   = JMP_J;
            end
            OP_LW: begin
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.ext_op     = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.ext_op    = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.is_r      = 1'b1;
            end
            default: o_undef = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_ctrl_stage.sv
`default_nettype none
//============================================================================
// Module      : decode_ctrl_stage
// Description : Registered decode stage: output bundle register with
//               valid/ready, multiply issue stall and sticky undef exception.
// Revision    : 1.0 - initial release
//============================================================================
module decode_ctrl_stage
    import cpu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int XLEN        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    decode_ctrl_stage_if.slave bus
);

    localparam logic [3:0] c_MUL_LOAD  = 4'(MULT_CYCLES - 1);
    localparam logic       c_MUL_STALL = (MULT_CYCLES > 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic            r_live;
    ctrl_t           r_ctrl;
    logic            r_out_valid;
    logic            r_exc_valid;
    logic [XLEN-1:0] r_exc_addr;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_mul_busy;
    ctrl_t           w_dec;
    logic            w_undef;
    logic            w_is_mult;
    logic            w_unused_instr;

    assign w_unused_instr = &{1'b0, bus.instr[25:21], bus.instr[15:6]};

    instr_decoder u_dec (
        .i_op      (bus.instr[31:26]),
        .i_rt      (bus.instr[20:16]),
        .i_funct   (bus.instr[5:0]),
        .o_ctrl    (w_dec),
        .o_undef   (w_undef),
        .o_is_mult (w_is_mult)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_live holds off issue until the first edge after reset release
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_mul_busy  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_in_ready = r_live && (!r_out_valid || bus.out_ready);
                w_accept   = bus.in_valid && w_in_ready && !bus.flush;
                if (w_accept) begin
                    if (w_undef) begin
                        w_state_nxt = ST_EXC_HOLD;
                    end else if (w_is_mult && c_MUL_STALL) begin
                        w_state_nxt = ST_MUL_WAIT;
                        w_cnt_nxt   = c_MUL_LOAD;
                    end
                end
            end
            ST_MUL_WAIT: begin
                w_mul_busy = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_EXC_HOLD: begin
                if (bus.exc_ack) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live      <= 1'b0;
            r_ctrl      <= '0;
            r_out_valid <= 1'b0;
            r_exc_valid <= 1'b0;
            r_exc_addr  <= '0;
        end else begin
            r_live <= 1'b1;
            if (bus.flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept && !w_undef) begin
                r_out_valid <= 1'b1;
                r_ctrl      <= w_dec;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && w_undef) begin
                r_exc_valid <= 1'b1;
                r_exc_addr  <= bus.pc_plus4 - XLEN'(4);
            end else if (r_state == ST_EXC_HOLD && bus.exc_ack) begin
                r_exc_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.ext_op     = r_ctrl.ext_op;
    assign bus.reg_dst    = r_ctrl.reg_dst;
    assign bus.branch     = r_ctrl.branch;
    assign bus.mem_read   = r_ctrl.mem_read;
    assign bus.mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.mem_write  = r_ctrl.mem_write;
    assign bus.reg_write  = r_ctrl.reg_write;
    assign bus.alu_src    = r_ctrl.alu_src;
    assign bus.sign       = r_ctrl.sign;
    assign bus.is_r       = r_ctrl.is_r;
    assign bus.alu_op     = r_ctrl.alu_op;
    assign bus.pattern    = r_ctrl.pattern;
    assign bus.jump       = r_ctrl.jump;
    assign bus.mul_busy   = w_mul_busy;
    assign bus.exc_valid  = r_exc_valid;
    assign bus.exc_addr   = r_exc_addr;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
`default_nettype none
//============================================================================
// Module      : tb_decode_ctrl_stage
// Description : Self-checking bench for decode_ctrl_stage with a table-level
//               decode reference and a transaction-level stall model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_decode_ctrl_stage;

    localparam int MULT_CYCLES = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    decode_ctrl_stage_if #(.XLEN(32)) bus ();

    decode_ctrl_stage #(.MULT_CYCLES(MULT_CYCLES), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [20:0] dut_b = {bus.ext_op, bus.reg_dst, bus.branch, bus.mem_read,
                         bus.mem_to_reg, bus.mem_write, bus.reg_write,
                         bus.alu_src, bus.sign, bus.is_r,
                         bus.alu_op, bus.pattern, bus.jump};

    function automatic logic [31:0] mk_r(input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd4, rt, 16'h0010};
    endfunction

    // {undef, ext,rdst,br,mrd,m2r,mwr,rwr,asrc,sgn,isr, alu[5], pat[3], jmp[3]}
    function automatic logic [21:0] ref_decode(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        logic       ext, rdst, br, mrd, m2r, mwr, rwr, asrc, sgn, isr, ud;
        logic [4:0] alu;
        logic [2:0] pat, jmp;
        logic [4:0] rtab [0:7];
        rtab = '{5'd1, 5'd1, 5'd2, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        op = w[31:26]; fn = w[5:0]; rt = w[20:16];
        {ext, rdst, br, mrd, m2r, mwr, rwr, asrc, sgn, isr, ud} = '0;
        alu = 5'd0; pat = 3'd0; jmp = 3'd0;
        if (op == 6'h00) begin
            if (fn >= 6'h20 && fn <= 6'h27) begin
                rdst = 1; rwr = 1; isr = 1; alu = rtab[fn[2:0]];
                sgn = (fn == 6'h20) || (fn == 6'h22);
            end else if (fn == 6'h18) begin
                alu = 5'd7; rdst = 1; rwr = 1; isr = 1; sgn = 1;
            end else if (fn == 6'h08) begin
                br = 1; jmp = 3'd2; alu = 5'd1;
            end else ud = 1;
        end else if (op == 6'h01) begin
            if (rt <= 5'd1) begin
                br = 1; alu = 5'd2; ext = 1; pat = (rt == 5'd0) ? 3'd4 : 3'd5;
            end else ud = 1;
        end else if (op == 6'h07 || op == 6'h05 || op == 6'h06) begin
            br = 1; alu = 5'd2; ext = 1; isr = (op == 6'h05);
            pat = (op == 6'h07) ? 3'd1 : (op == 6'h05) ? 3'd2 : 3'd3;
        end else if (op == 6'h08 || op == 6'h09) begin
            alu = 5'd1; asrc = 1; ext = 1; rwr = 1; sgn = (op == 6'h08);
        end else if (op == 6'h0C) begin
            alu = 5'd3; asrc = 1; rwr = 1;
        end else if (op == 6'h02) begin
            br = 1; jmp = 3'd1;
        end else if (op == 6'h23) begin
            alu = 5'd1; asrc = 1; ext = 1; mrd = 1; m2r = 1; rwr = 1;
        end else if (op == 6'h2B) begin
            alu = 5'd1; asrc = 1; ext = 1; mwr = 1; isr = 1;
        end else ud = 1;
        return {ud, ext, rdst, br, mrd, m2r, mwr, rwr, asrc, sgn, isr, alu, pat, jmp};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 0; bus.instr = '0; bus.pc_plus4 = 32'h00400004;
        bus.flush = 0; bus.out_ready = 1; bus.exc_ack = 0;
        tick(); tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b need 0", bus.out_valid); end
        n_checks++; if (bus.exc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_exc_valid: got %b need 0", bus.exc_valid); end
        n_checks++; if (bus.exc_addr !== 32'h0) begin n_fail++; $display("FAIL reset_exc_addr: got %h need 0", bus.exc_addr); end
        n_checks++; if (bus.mul_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mul_busy: got %b need 0", bus.mul_busy); end
        n_checks++; if (dut_b !== 21'h0) begin n_fail++; $display("FAIL reset_bundle: got %h need 0", dut_b); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_pre: got %b need 0", bus.in_ready); end
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_post: got %b need 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [0:2];
        logic [21:0] exp;
        seq = '{mk_r(6'h20), mk_i(6'h23, 5'd5), mk_i(6'h2B, 5'd5)};
        bus.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.instr = seq[i];
            #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b need 1", i, bus.in_ready); end
            tick();
            exp = ref_decode(seq[i]);
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid[%0d]: got %b need 1", i, bus.out_valid); end
            n_checks++; if (dut_b !== exp[20:0]) begin n_fail++; $display("FAIL b2b_bundle[%0d]: got %h need %h", i, dut_b, exp[20:0]); end
        end
        n_checks++; if ({bus.alu_op, bus.mem_write, bus.is_r} !== {5'd1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL b2b_sw_fields: got %h need %h", {bus.alu_op, bus.mem_write, bus.is_r}, {5'd1, 2'b11}); end
        bus.in_valid = 0;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b need 0", bus.out_valid); end
    endtask

    task automatic test_mult();
        int cycles;
        logic [21:0] exp;
        bus.out_ready = 1; bus.in_valid = 1; bus.instr = mk_r(6'h18);
        #1;
        tick();
        exp = ref_decode(mk_r(6'h18));
        n_checks++; if (dut_b !== exp[20:0]) begin n_fail++; $display("FAIL mult_bundle: got %h need %h", dut_b, exp[20:0]); end
        bus.instr = mk_r(6'h21);
        cycles = 0;
        while (bus.in_ready !== 1'b1 && cycles < 20) begin
            n_checks++; if (bus.mul_busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy[%0d]: got %b need 1", cycles, bus.mul_busy); end
            tick();
            cycles++;
        end
        n_checks++; if (cycles != MULT_CYCLES - 1) begin n_fail++; $display("FAIL mult_stall_cycles: got %0d need %0d", cycles, MULT_CYCLES - 1); end
        tick();
        bus.in_valid = 0;
        exp = ref_decode(mk_r(6'h21));
        n_checks++; if (bus.out_valid !== 1'b1 || dut_b !== exp[20:0]) begin n_fail++; $display("FAIL mult_addu: got v=%b %h need v=1 %h", bus.out_valid, dut_b, exp[20:0]); end
        tick();
    endtask

    task automatic test_exception();
        bus.out_ready = 1; bus.in_valid = 1; bus.instr = 32'hFC000000; bus.pc_plus4 = 32'h00400014;
        #1;
        tick();
        bus.in_valid = 0;
        n_checks++; if (bus.exc_valid !== 1'b1) begin n_fail++; $display("FAIL exc_valid: got %b need 1", bus.exc_valid); end
        n_checks++; if (bus.exc_addr !== 32'h00400010) begin n_fail++; $display("FAIL exc_addr: got %h need 00400010", bus.exc_addr); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL exc_out_valid: got %b need 0", bus.out_valid); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.in_ready !== 1'b0 || bus.exc_valid !== 1'b1) begin n_fail++; $display("FAIL exc_hold[%0d]: got rdy=%b exc=%b need rdy=0 exc=1", i, bus.in_ready, bus.exc_valid); end
            tick();
        end
        bus.exc_ack = 1;
        tick();
        bus.exc_ack = 0;
        n_checks++; if (bus.exc_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL exc_ack: got exc=%b rdy=%b need exc=0 rdy=1", bus.exc_valid, bus.in_ready); end
        bus.exc_ack = 1;
        tick();
        bus.exc_ack = 0;
        n_checks++; if (bus.exc_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL exc_stray_ack: got exc=%b rdy=%b need exc=0 rdy=1", bus.exc_valid, bus.in_ready); end
        bus.in_valid = 1; bus.flush = 1; bus.instr = 32'hFC000000;
        tick();
        bus.in_valid = 0; bus.flush = 0;
        n_checks++; if (bus.exc_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL exc_flushed: got exc=%b rdy=%b need exc=0 rdy=1", bus.exc_valid, bus.in_ready); end
    endtask

    task automatic test_regimm();
        logic [21:0] exp;
        bus.out_ready = 1; bus.in_valid = 1; bus.pc_plus4 = 32'h00400100;
        bus.instr = mk_i(6'h01, 5'd1);
        tick();
        exp = ref_decode(mk_i(6'h01, 5'd1));
        n_checks++; if (bus.pattern !== 3'd5 || dut_b !== exp[20:0]) begin n_fail++; $display("FAIL bgez: got pat=%0d %h need pat=5 %h", bus.pattern, dut_b, exp[20:0]); end
        bus.instr = mk_i(6'h01, 5'd0);
        tick();
        exp = ref_decode(mk_i(6'h01, 5'd0));
        n_checks++; if (bus.pattern !== 3'd4 || dut_b !== exp[20:0]) begin n_fail++; $display("FAIL bltz: got pat=%0d %h need pat=4 %h", bus.pattern, dut_b, exp[20:0]); end
        bus.instr = mk_i(6'h01, 5'd2);
        tick();
        bus.in_valid = 0;
        n_checks++; if (bus.exc_valid !== 1'b1 || bus.out_valid !== 1'b0 || bus.exc_addr !== 32'h004000FC) begin n_fail++; $display("FAIL regimm_rt2: got exc=%b ov=%b addr=%h need exc=1 ov=0 addr=004000fc", bus.exc_valid, bus.out_valid, bus.exc_addr); end
        bus.exc_ack = 1;
        tick();
        bus.exc_ack = 0;
    endtask

    task automatic test_hold_flush();
        logic [21:0] exp;
        bus.out_ready = 0; bus.in_valid = 1; bus.instr = mk_r(6'h20);
        tick();
        bus.instr = mk_i(6'h23, 5'd0);
        exp = ref_decode(mk_r(6'h20));
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.out_valid !== 1'b1 || dut_b !== exp[20:0] || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold[%0d]: got ov=%b %h rdy=%b need ov=1 %h rdy=0", i, bus.out_valid, dut_b, bus.in_ready, exp[20:0]); end
            tick();
        end
        bus.flush = 1;
        tick();
        bus.flush = 0; bus.in_valid = 0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b need 0", bus.out_valid); end
        bus.out_ready = 1;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: got ov=%b rdy=%b need ov=0 rdy=1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_reset_mid_mul();
        bus.out_ready = 0; bus.in_valid = 1; bus.instr = mk_r(6'h18);
        tick();
        bus.in_valid = 0;
        tick();
        n_checks++; if (bus.mul_busy !== 1'b1) begin n_fail++; $display("FAIL rstmul_busy_before: got %b need 1", bus.mul_busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.out_valid, bus.exc_valid, bus.mul_busy, bus.in_ready} !== 4'b0 || dut_b !== 21'h0 || bus.exc_addr !== 32'h0) begin n_fail++; $display("FAIL rstmul_outputs: got ov=%b exc=%b busy=%b rdy=%b b=%h addr=%h need all 0", bus.out_valid, bus.exc_valid, bus.mul_busy, bus.in_ready, dut_b, bus.exc_addr); end
        bus.out_ready = 1;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmul_rdy_pre: got %b need 0", bus.in_ready); end
        tick();
        n_checks++; if (bus.in_ready !== 1'b1 || bus.mul_busy !== 1'b0) begin n_fail++; $display("FAIL rstmul_rdy_post: got rdy=%b busy=%b need rdy=1 busy=0", bus.in_ready, bus.mul_busy); end
    endtask

    task automatic test_random();
        logic [31:0] base [0:20];
        logic [31:0] w;
        logic [21:0] exp;
        logic [20:0] m_b;
        logic        m_ov;
        logic        exp_rdy;
        int          mul_left;
        base = '{mk_r(6'h20), mk_r(6'h21), mk_r(6'h22), mk_r(6'h23), mk_r(6'h24),
                 mk_r(6'h25), mk_r(6'h26), mk_r(6'h27), mk_r(6'h18), mk_r(6'h08),
                 mk_i(6'h08, 5'd0), mk_i(6'h09, 5'd0), mk_i(6'h0C, 5'd0),
                 mk_i(6'h07, 5'd0), mk_i(6'h05, 5'd0), mk_i(6'h06, 5'd0),
                 mk_i(6'h01, 5'd0), mk_i(6'h01, 5'd1), mk_i(6'h02, 5'd0),
                 mk_i(6'h23, 5'd0), mk_i(6'h2B, 5'd0)};
        bus.in_valid = 0; bus.out_ready = 1; bus.flush = 0;
        tick(); tick();
        m_ov = 0; m_b = '0; mul_left = 0;
        for (int c = 0; c < 400; c++) begin
            w = base[$urandom_range(0, 20)];
            w[25:21] = 5'($urandom);
            w[15:6]  = 10'($urandom);
            if (w[31:26] != 6'h01) w[20:16] = 5'($urandom);
            bus.instr     = w;
            bus.pc_plus4  = $urandom;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (mul_left == 0) && (!m_ov || bus.out_ready);
            n_checks++; if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b need %b", c, bus.in_ready, exp_rdy); end
            n_checks++; if (bus.out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_out_valid[%0d]: got %b need %b", c, bus.out_valid, m_ov); end
            n_checks++; if (bus.mul_busy !== (mul_left > 0)) begin n_fail++; $display("FAIL rnd_mul_busy[%0d]: got %b need %b", c, bus.mul_busy, mul_left > 0); end
            if (m_ov) begin
                n_checks++; if (dut_b !== m_b) begin n_fail++; $display("FAIL rnd_bundle[%0d]: got %h need %h", c, dut_b, m_b); end
            end
            if (mul_left > 0) mul_left--;
            if (bus.in_valid && exp_rdy) begin
                exp = ref_decode(w);
                m_ov = 1; m_b = exp[20:0];
                if (w[31:26] == 6'h00 && w[5:0] == 6'h18) mul_left = MULT_CYCLES - 1;
            end else if (bus.out_ready) begin
                m_ov = 0;
            end
            tick();
        end
        bus.in_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_back_to_back();
        test_mult();
        test_exception();
        test_regimm();
        test_hold_flush();
        test_reset_mid_mul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered instruction-decode control stage for the pipelined MIPS core, sitting between the IF/ID register and the ID/EX register. It decodes one 32-bit instruction per accepted beat into the datapath control bundle. Results are held in an output register with a valid/ready handshake. It also stalls issue behind a multi-cycle multiply and raises a sticky undefined-instruction exception with the faulting PC.

## Interface
- `MULT_CYCLES`, default 4: multiply-unit occupancy in cycles; legal range 1..15.
- `XLEN`, default 32: width of `instr`, `pc_plus4` and `exc_addr`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage accepts this cycle.
- `instr`  in  XLEN  instruction word.
- `pc_plus4`  in  XLEN  PC+4 of `instr`.
- `flush`  in  1  branch-redirect kill.
- `out_valid`  out  1  control bundle valid.
- `out_ready`  in  1  downstream accepts bundle.
- `ext_op`, `reg_dst`, `branch`, `mem_read`, `mem_to_reg`, `mem_write`, `reg_write`, `alu_src`, `sign`, `is_r`  out  1 each  control bundle bits.
- `alu_op`  out  5  ALU operation code.
- `pattern`  out  3  branch-condition code.
- `jump`  out  3  jump kind.
- `mul_busy`  out  1  multiply occupancy active.
- `exc_valid`  out  1  undefined-instruction exception pending.
- `exc_addr`  out  XLEN  faulting PC, equal to `pc_plus4 - 4`.
- `exc_ack`  in  1  exception consumed.

## Operation
- Decode rule: every bundle bit defaults to 0. Only the bits listed per instruction are set.
- R-type ALU (SPECIAL funct add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27):
  - `reg_dst`=1, `reg_write`=1, `is_r`=1.
  - `alu_op`: add/addu 1, sub/subu 2, and 3, or 4, xor 5, nor 6.
  - `sign`=1 for add and sub only.
- mult (funct 18): `alu_op`=7, `reg_dst`=1, `reg_write`=1, `is_r`=1, `sign`=1. Starts the multiply occupancy.
- jr (funct 08): `branch`=1, `jump`=2, `alu_op`=1.
- addi / addiu (op 08/09): `alu_op`=1, `alu_src`=1, `ext_op`=1, `reg_write`=1. `sign`=1 for addi only.
- andi (op 0C): `alu_op`=3, `alu_src`=1, `reg_write`=1, `ext_op`=0 (zero-extend).
- Branches: all set `branch`=1, `alu_op`=2, `ext_op`=1.
  - `pattern`: bgtz (07) 1, bne (05) 2, blez (06) 3, bltz (01, rt=0) 4, bgez (01, rt=1) 5.
  - bne also sets `is_r`=1.
- j (op 02): `branch`=1, `jump`=1.
- lw (op 23): `alu_op`=1, `alu_src`=1, `ext_op`=1, `mem_read`=1, `mem_to_reg`=1, `reg_write`=1.
- sw (op 2B): `alu_op`=1, `alu_src`=1, `ext_op`=1, `mem_write`=1, `is_r`=1.
- Undefined encodings: any other opcode, other SPECIAL funct, or REGIMM rt not in {0,1}. Handling is defined in the FSM below.

FSM states:
- RUN:
  - `in_ready` = !`out_valid` | `out_ready`.
  - Accept = `in_valid` & `in_ready` & !`flush`.
  - A defined instruction loads the bundle and sets `out_valid`.
  - mult additionally loads the counter with `MULT_CYCLES`-1 and goes to MUL_WAIT. If `MULT_CYCLES`=1, it stays in RUN.
  - An undefined instruction loads `exc_addr`, sets `exc_valid`, emits no bundle, and goes to EXC_HOLD.
- MUL_WAIT:
  - `in_ready`=0, `mul_busy`=1.
  - The counter decrements each cycle and returns to RUN when it equals 1.
- EXC_HOLD:
  - `in_ready`=0.
  - On `exc_ack`: clear `exc_valid` and go to RUN.
- `flush`:
  - Clears `out_valid` and suppresses that cycle's accept.
  - Does not affect the MUL_WAIT counter or a pending exception.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle when `out_ready`=1.
- Output hold: the bundle is held stable while `out_valid` & !`out_ready`.
- Simultaneous `out_ready` and a new accept: the bundle is replaced the same edge, with no bubble.
- Reset (asynchronous assert, any state, including mid-MUL_WAIT):
  - State goes to RUN, counter to 0.
  - All outputs go to 0, including `out_valid`, `exc_valid`, `exc_addr` and `mul_busy`.
  - `in_ready` becomes 1 after the first edge with `rst_n` high.
- `exc_ack` while `exc_valid`=0 is ignored.
- `flush` and an undefined instruction in the same cycle: the instruction is killed and no exception is raised.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - opcode/funct localparams;
  - `alu_op`, `pattern` and `jump` codes;
  - the state enum RUN/MUL_WAIT/EXC_HOLD.
- Natural sub-module `instr_decoder`: purely combinational `instr` -> bundle plus an `undef` flag. This stage wraps it with the FSM, counter and output register.

## Test plan
- Back-to-back add, lw, sw with `out_ready`=1 -> three bundles on consecutive cycles.
  - add: `alu_op`=1, `reg_dst`=1, `sign`=1.
  - lw: `mem_read`=1, `mem_to_reg`=1.
  - sw: `mem_write`=1, `is_r`=1.
- mult with `MULT_CYCLES`=4, followed by addu -> `in_ready` low for 3 cycles, then addu accepted.
- Word 0xFC000000 at `pc_plus4`=0x00400014:
  - `exc_valid`=1, `exc_addr`=0x00400010, `out_valid` stays 0;
  - `in_ready` low until `exc_ack`, then returns to 1.
- bgez vs bltz (op 01, rt 1 and rt 0) -> `pattern` 5 vs 4. REGIMM rt=2 -> exception.
- `out_ready` low for 3 cycles with a valid bundle -> bundle stable, `in_ready`=0. Assert `flush` -> `out_valid`=0 next cycle.
- `rst_n` pulsed low mid-MUL_WAIT -> all outputs 0 immediately, `in_ready`=1 after release.
